// File: rtl/regbank_wb_queue.sv
// Write-back queue in front of the 16-entry register bank: two producers, one bank write port, r15 writes dropped.
// Define REGBANK_WBQ_FWD_EN to build the pending-result lookup port; otherwise fwd_hit/fwd_data are tied low.
module regbank_wb_queue #(
    parameter int BUS   = 32,
    parameter int DIR   = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [DIR-1:0]           alu_rd,
    input  logic [BUS-1:0]           alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [DIR-1:0]           ld_rd,
    input  logic [BUS-1:0]           ld_data,
    output logic                     ld_ready,
    output logic [DIR-1:0]           rd_o,
    output logic [BUS-1:0]           wb_o,
    output logic                     we_o,
    input  logic [DIR-1:0]           fwd_addr,
    output logic                     fwd_hit,
    output logic [BUS-1:0]           fwd_data,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [DIR-1:0] PC_REG = '1;

    typedef struct packed {
        logic [DIR-1:0] rd;
        logic [BUS-1:0] data;
    } entry_t;

    entry_t         r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    entry_t         r_out;
    logic           r_we;
    logic           r_err;

    logic           w_alu_acc;
    logic           w_ld_acc;
    logic           w_alu_push;
    logic           w_ld_push;
    logic           w_pop;
    logic [1:0]     w_push_cnt;

    // Ready looks only at registered occupancy, so a full queue never accepts even while draining.
    assign alu_ready  = r_count < CW'(DEPTH);
    assign ld_ready   = alu_valid ? (r_count < CW'(DEPTH - 1)) : (r_count < CW'(DEPTH));

    assign w_alu_acc  = alu_valid && alu_ready;
    assign w_ld_acc   = ld_valid && ld_ready;
    assign w_alu_push = w_alu_acc && (alu_rd != PC_REG);
    assign w_ld_push  = w_ld_acc && (ld_rd != PC_REG);
    assign w_pop      = r_count != '0;
    assign w_push_cnt = {1'b0, w_alu_push} + {1'b0, w_ld_push};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_out    <= '0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_push_cnt) - CW'(w_pop);
            r_we     <= w_pop;
            if (w_pop) begin
                r_out <= r_mem[r_rd_ptr];
            end
            if ((w_alu_acc && !w_alu_push) || (w_ld_acc && !w_ld_push)) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: storage has no reset; occupancy and pointers alone decide which slots are meaningful.
    always_ff @(posedge clk) begin
        if (w_alu_push) begin
            r_mem[r_wr_ptr] <= '{rd: alu_rd, data: alu_data};
        end
        if (w_ld_push) begin
            r_mem[r_wr_ptr + PW'(w_alu_push)] <= '{rd: ld_rd, data: ld_data};
        end
    end

    assign rd_o    = r_out.rd;
    assign wb_o    = r_out.data;
    assign we_o    = r_we;
    assign err_o   = r_err;
    assign count_o = r_count;

`ifdef REGBANK_WBQ_FWD_EN
    // Output register is lowest priority; FIFO entries are scanned oldest to youngest so the youngest wins.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (r_we && (r_out.rd == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = r_out.data;
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if ((CW'(k) < r_count) && (r_mem[r_wr_ptr - PW'(k + 1)].rd == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = r_mem[r_wr_ptr - PW'(k + 1)].data;
            end
        end
    end
`else
    logic w_unused_fwd_addr;
    assign w_unused_fwd_addr = ^fwd_addr;
    assign fwd_hit           = 1'b0;
    assign fwd_data          = '0;
`endif

endmodule
